// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, fixed
// response latency, RISC-V byte/half/word access with error classification.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [2:0]  i_req_funct3,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_error
);
    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_cnt, w_cnt_nxt;
    logic               r_write, r_err;
    logic [1:0]         r_lane;
    logic [2:0]         r_funct3;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_mem [DEPTH_WORDS];
    logic               r_rsp_valid, r_rsp_error;
    logic [31:0]        r_rsp_rdata;

    logic               w_accept, w_err, w_enter_resp, w_leave_resp;
    logic               w_src_write, w_src_err;
    logic [2:0]         w_src_f3;
    logic [1:0]         w_src_lane;
    logic [IDX_W-1:0]   w_idx_in, w_src_idx;
    logic [3:0]         w_be;
    logic [31:0]        w_wlanes;

    function automatic logic is_bad(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        logic bad_f3, misal, range_bad;
        bad_f3    = wr ? (f3[2] | (f3[1:0] == 2'b11)) : ((f3 == 3'b011) | (f3[2:1] == 2'b11));
        misal     = ((f3[1:0] == 2'b01) & addr[0]) | ((f3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        range_bad = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
        return bad_f3 | misal | range_bad;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {lane, 3'b000});
        h = 16'(word >> {lane[1], 4'b0000});
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            3'b010:  return word;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    assign w_idx_in = i_req_addr[IDX_W+1:2];
    assign w_err    = is_bad(i_req_write, i_req_funct3, i_req_addr);
    assign w_accept = i_req_valid & o_req_ready & ~i_rst;
    assign w_be     = store_be(i_req_funct3, i_req_addr[1:0]);
    assign w_wlanes = (i_req_funct3[1:0] == 2'b00) ? {4{i_req_wdata[7:0]}} :
                      (i_req_funct3[1:0] == 2'b01) ? {2{i_req_wdata[15:0]}} : i_req_wdata;

    // Next-state, latency counter and handshake decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        o_req_ready  = 1'b0;
        w_enter_resp = 1'b0;
        w_leave_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (LATENCY > 1) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end else begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                // rsp_valid rises one edge after entering RESP; ready is ignored until then.
                if (r_rsp_valid && i_rsp_ready) begin
                    w_state_nxt  = S_IDLE;
                    w_leave_resp = 1'b1;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Response source: live request when responding straight from IDLE, else the latched one.
    always_comb begin
        w_src_write = r_write;
        w_src_err   = r_err;
        w_src_f3    = r_funct3;
        w_src_lane  = r_lane;
        w_src_idx   = r_idx;
        if (r_state == S_IDLE) begin
            w_src_write = i_req_write;
            w_src_err   = w_err;
            w_src_f3    = i_req_funct3;
            w_src_lane  = i_req_addr[1:0];
            w_src_idx   = w_idx_in;
        end else begin
            w_src_write = r_write;
        end
    end

    // FSM state and latency counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Latch and classify the request on the accept edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_lane   <= 2'd0;
            r_funct3 <= 3'd0;
            r_idx    <= '0;
        end else if (w_accept) begin
            r_write  <= i_req_write;
            r_err    <= w_err;
            r_lane   <= i_req_addr[1:0];
            r_funct3 <= i_req_funct3;
            r_idx    <= w_idx_in;
        end
    end

    // Store commit at accept; contents are intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (w_accept && i_req_write && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx_in][8*b +: 8] <= w_wlanes[8*b +: 8];
                end
            end
        end
    end

    // Response registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b0;
        end else if (w_enter_resp) begin
            r_rsp_error <= w_src_err;
            r_rsp_rdata <= (w_src_err || w_src_write) ? 32'd0
                           : load_extract(r_mem[w_src_idx], w_src_f3, w_src_lane);
        end else if (w_leave_resp) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b0;
        end else if (r_state == S_RESP) begin
            r_rsp_valid <= 1'b1;
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_error = r_rsp_error;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected
// responses; a negedge monitor pops and compares on each response handshake.
module tb_dmem_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        req_ready, rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .i_req_funct3(req_funct3), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;
    exp_t q[$];

    int   vectors = 0, errors = 0, cyc = 0, first_cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid && !prev_valid) first_cyc = cyc;
        prev_valid = rsp_valid;
        if (rsp_valid && rsp_ready && !rst) begin
            if (q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_rsp: got response %h with nothing expected", rsp_rdata);
            end else begin
                e = q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_error", 32'(rsp_error), 32'(e.err));
                check("latency", 32'(first_cyc - e.acc), 32'(LAT));
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input logic [31:0] er, input logic ee,
                         input bit push);
        bit   done = 1'b0;
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_funct3 = f3;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                e.rdata = er; e.err = ee; e.acc = cyc + 1;
                if (push) q.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL accept_timeout: got no accept for addr %h expected accept", a);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_funct3 = 3'($urandom);
        if (done) begin
            @(negedge clk);
            check("req_ready_busy", 32'(req_ready), 32'd0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_error", 32'(rsp_error), 32'd0);

        // Basic word store/load
        issue(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'd0, 1'b0, 1'b1);
        issue(1'b0, 32'h10, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0, 1'b1);

        // Sign/zero extension
        issue(1'b1, 32'h20, 32'h80FF7F01, 3'b010, 32'd0, 1'b0, 1'b1);
        issue(1'b0, 32'h23, 32'd0, 3'b000, 32'hFFFFFF80, 1'b0, 1'b1);
        issue(1'b0, 32'h23, 32'd0, 3'b100, 32'h00000080, 1'b0, 1'b1);
        issue(1'b0, 32'h22, 32'd0, 3'b001, 32'hFFFF80FF, 1'b0, 1'b1);
        issue(1'b0, 32'h22, 32'd0, 3'b101, 32'h000080FF, 1'b0, 1'b1);
        issue(1'b0, 32'h20, 32'd0, 3'b000, 32'h00000001, 1'b0, 1'b1);

        // Partial stores merge into an existing word
        issue(1'b1, 32'h30, 32'h11223344, 3'b010, 32'd0, 1'b0, 1'b1);
        issue(1'b1, 32'h31, 32'h123456AA, 3'b000, 32'd0, 1'b0, 1'b1);
        issue(1'b1, 32'h32, 32'h9999BBCC, 3'b001, 32'd0, 1'b0, 1'b1);
        issue(1'b0, 32'h30, 32'd0, 3'b010, 32'hBBCCAA44, 1'b0, 1'b1);

        // Error cases leave memory untouched
        issue(1'b1, 32'h04, 32'h01020304, 3'b010, 32'd0, 1'b0, 1'b1);
        issue(1'b0, 32'h06, 32'd0, 3'b010, 32'd0, 1'b1, 1'b1);
        issue(1'b1, 32'h05, 32'h0000FFFF, 3'b001, 32'd0, 1'b1, 1'b1);
        issue(1'b0, 32'(4 * DEPTH), 32'd0, 3'b010, 32'd0, 1'b1, 1'b1);
        issue(1'b0, 32'h10, 32'd0, 3'b011, 32'd0, 1'b1, 1'b1);
        issue(1'b1, 32'h10, 32'hFFFFFFFF, 3'b100, 32'd0, 1'b1, 1'b1);
        issue(1'b0, 32'h04, 32'd0, 3'b010, 32'h01020304, 1'b0, 1'b1);
        issue(1'b0, 32'h10, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0, 1'b1);
        drain();

        // Backpressure: responses frozen, no new accept while stalled
        @(posedge clk); #1 rsp_ready = 1'b0;
        issue(1'b0, 32'h30, 32'd0, 3'b010, 32'hBBCCAA44, 1'b0, 1'b1);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        check("bp_valid_seen", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'hBBCCAA44);
            check("bp_rsp_error", 32'(rsp_error), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_idle", 32'(req_ready), 32'd1);
        check("bp_release_valid", 32'(rsp_valid), 32'd0);

        // Reset while waiting: response dropped, committed store kept
        issue(1'b1, 32'h40, 32'h00000055, 3'b010, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_wait_valid", 32'(rsp_valid), 32'd0);
        check("rst_wait_ready", 32'(req_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        issue(1'b0, 32'h40, 32'd0, 3'b010, 32'h00000055, 1'b0, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
